dmem_responder: RTL and testbench

Data-memory responder for the ECNURVCORE pipeline. It is the slave end of the execute stage's memory request port. It accepts the execute stage's read and write requests (enable, address, store data, access size), owns a single-port 64-bit-wide data array, performs read-modify-write for sub-doubleword stores, and returns aligned doubleword read data. Sign/zero extension and byte extraction stay downstream in the EX/MEM register. The block raises a pipeline hold request whenever it needs more than one cycle for a request.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_byte_merge.sv | 30 +++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: access size codes, FSM states
// and the bus widths reused from the core.
package dmem_responder_pkg;

  localparam int BUS_ADDR_MEM = 64;
  localparam int BUS_DATA_MEM = 64;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE    = 2'd0,
    DMEM_ST_RMW     = 2'd1,
    DMEM_ST_PEND_RD = 2'd2
  } dmem_state_e;

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SIZE_B:  mask = 3'b000;
      SIZE_H:  mask = 3'b001;
      SIZE_W:  mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational lane merge: overlays a right-justified store of 1/2/4/8 bytes
// onto an old doubleword at the given byte offset.
module dmem_byte_merge
  import dmem_responder_pkg::*;
(
  input  logic [BUS_DATA_MEM-1:0] old_word,
  input  logic [BUS_DATA_MEM-1:0] new_data,
  input  logic [2:0]              offset,
  input  logic [1:0]              size,
  output logic [BUS_DATA_MEM-1:0] merged
);

  logic [BUS_DATA_MEM-1:0] size_lanes_s;
  logic [BUS_DATA_MEM-1:0] lane_mask_s;
  logic [BUS_DATA_MEM-1:0] shifted_data_s;

  // Build the byte-lane mask for the store and combine old and new lanes
  always_comb begin
    case (size)
      SIZE_B:  size_lanes_s = 64'h0000_0000_0000_00FF;
      SIZE_H:  size_lanes_s = 64'h0000_0000_0000_FFFF;
      SIZE_W:  size_lanes_s = 64'h0000_0000_FFFF_FFFF;
      default: size_lanes_s = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    lane_mask_s    = size_lanes_s << {offset, 3'b000};
    shifted_data_s = new_data << {offset, 3'b000};
    merged         = (old_word & ~lane_mask_s) | (shifted_data_s & lane_mask_s);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port 64-bit array with read-modify-write for
// sub-doubleword stores. Define DMEM_MISALIGN_CHK_EN to reject misaligned requests.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = BUS_ADDR_MEM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_wr_en_i,
  input  logic [ADDR_W-1:0]       addr_mem_wr_i,
  input  logic [BUS_DATA_MEM-1:0] data_mem_wr_i,
  input  logic [1:0]              wr_size_i,
  input  logic                    mem_rd_en_i,
  input  logic [ADDR_W-1:0]       addr_mem_rd_i,
  input  logic [1:0]              rd_size_i,
  output logic [BUS_DATA_MEM-1:0] rd_data_o,
  output logic                    rd_vld_o,
  output logic                    hold_req_o,
  output logic                    err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [BUS_DATA_MEM-1:0] mem_r [DEPTH_WORDS];

  dmem_state_e             state_r, next_state_s;
  logic [IDX_W-1:0]        wr_idx_s, rd_idx_s, mem_idx_s, rd_sel_idx_s;
  logic [IDX_W-1:0]        rmw_idx_r, pend_idx_r;
  logic [2:0]              wr_off_s, rmw_off_r;
  logic [1:0]              rmw_size_r;
  logic [BUS_DATA_MEM-1:0] rmw_data_r, old_word_r, merged_s, mem_wdata_s;
  logic [BUS_DATA_MEM-1:0] rd_data_r;
  logic                    wr_mis_s, rd_mis_s, wr_ok_s, rd_ok_s, wr_sub_s;
  logic                    mem_we_s, rd_fire_s, pend_set_s, pend_nxt_s, err_s, rmw_cap_s;
  logic                    pend_rd_r, rd_vld_r, hold_r, err_r;
  logic                    unused_bits_s;

  assign wr_idx_s = addr_mem_wr_i[3 +: IDX_W];
  assign rd_idx_s = addr_mem_rd_i[3 +: IDX_W];
  assign unused_bits_s = ^{addr_mem_wr_i[ADDR_W-1:IDX_W+3], addr_mem_rd_i[ADDR_W-1:IDX_W+3],
                           addr_mem_rd_i[2:0], rd_size_i};

`ifdef DMEM_MISALIGN_CHK_EN
  assign wr_mis_s = |(addr_mem_wr_i[2:0] & size_mask(wr_size_i));
  assign rd_mis_s = |(addr_mem_rd_i[2:0] & size_mask(rd_size_i));
  assign wr_off_s = addr_mem_wr_i[2:0];
`else
  // Misaligned stores are silently snapped down to their natural boundary
  assign wr_mis_s = 1'b0;
  assign rd_mis_s = 1'b0;
  assign wr_off_s = addr_mem_wr_i[2:0] & ~size_mask(wr_size_i);
`endif

  assign wr_ok_s  = mem_wr_en_i & ~wr_mis_s;
  assign rd_ok_s  = mem_rd_en_i & ~rd_mis_s;
  assign wr_sub_s = (wr_size_i != SIZE_D);

  dmem_byte_merge u_merge (
    .old_word (old_word_r),
    .new_data (rmw_data_r),
    .offset   (rmw_off_r),
    .size     (rmw_size_r),
    .merged   (merged_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DMEM_ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    next_state_s = DMEM_ST_IDLE;
    case (state_r)
      DMEM_ST_IDLE: begin
        if (wr_ok_s && wr_sub_s) begin
          next_state_s = DMEM_ST_RMW;
        end else if (wr_ok_s && rd_ok_s) begin
          next_state_s = DMEM_ST_PEND_RD;
        end else begin
          next_state_s = DMEM_ST_IDLE;
        end
      end
      DMEM_ST_RMW:     next_state_s = pend_rd_r ? DMEM_ST_PEND_RD : DMEM_ST_IDLE;
      DMEM_ST_PEND_RD: next_state_s = DMEM_ST_IDLE;
      default:         next_state_s = DMEM_ST_IDLE;
    endcase
  end

  // FSM output decode: array port, read launch and pending-read bookkeeping
  always_comb begin
    mem_we_s     = 1'b0;
    mem_idx_s    = wr_idx_s;
    mem_wdata_s  = data_mem_wr_i;
    rd_fire_s    = 1'b0;
    rd_sel_idx_s = rd_idx_s;
    pend_set_s   = 1'b0;
    pend_nxt_s   = pend_rd_r;
    err_s        = 1'b0;
    rmw_cap_s    = 1'b0;
    case (state_r)
      DMEM_ST_IDLE: begin
        mem_we_s   = wr_ok_s & ~wr_sub_s;
        rmw_cap_s  = wr_ok_s & wr_sub_s;
        rd_fire_s  = rd_ok_s & ~wr_ok_s;
        pend_set_s = rd_ok_s & wr_ok_s;
        pend_nxt_s = rd_ok_s & wr_ok_s;
        err_s      = (mem_wr_en_i & wr_mis_s) | (mem_rd_en_i & rd_mis_s);
      end
      DMEM_ST_RMW: begin
        mem_we_s    = 1'b1;
        mem_idx_s   = rmw_idx_r;
        mem_wdata_s = merged_s;
      end
      DMEM_ST_PEND_RD: begin
        rd_fire_s    = 1'b1;
        rd_sel_idx_s = pend_idx_r;
        pend_nxt_s   = 1'b0;
      end
      default: begin
        pend_nxt_s = 1'b0;
      end
    endcase
  end

  // Array write port; reset suppresses any write, abandoning an in-flight merge
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Capture the sub-dword store, its old word, and any read that must wait
  always_ff @(posedge clk) begin
    if (rmw_cap_s) begin
      rmw_idx_r  <= wr_idx_s;
      rmw_off_r  <= wr_off_s;
      rmw_size_r <= wr_size_i;
      rmw_data_r <= data_mem_wr_i;
      old_word_r <= mem_r[wr_idx_s];
    end
    if (pend_set_s) begin
      pend_idx_r <= rd_idx_s;
    end
  end

  // Registered outputs and pending-read flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= 64'd0;
      rd_vld_r  <= 1'b0;
      hold_r    <= 1'b0;
      err_r     <= 1'b0;
      pend_rd_r <= 1'b0;
    end else begin
      if (rd_fire_s) begin
        rd_data_r <= mem_r[rd_sel_idx_s];
      end
      rd_vld_r  <= rd_fire_s;
      hold_r    <= (next_state_s != DMEM_ST_IDLE);
      err_r     <= err_s;
      pend_rd_r <= pend_nxt_s;
    end
  end

  assign rd_data_o  = rd_data_r;
  assign rd_vld_o   = rd_vld_r;
  assign hold_req_o = hold_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_wr_en_i = 1'b0;
  logic [63:0] addr_mem_wr_i = 64'd0;
  logic [63:0] data_mem_wr_i = 64'd0;
  logic [1:0]  wr_size_i = 2'd0;
  logic        mem_rd_en_i = 1'b0;
  logic [63:0] addr_mem_rd_i = 64'd0;
  logic [1:0]  rd_size_i = 2'd0;
  logic [63:0] rd_data_o;
  logic        rd_vld_o, hold_req_o, err_o;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0]  ref_mem [BYTES];
  logic [63:0] last_rd = 64'd0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wr_en_i   (mem_wr_en_i),
    .addr_mem_wr_i (addr_mem_wr_i),
    .data_mem_wr_i (data_mem_wr_i),
    .wr_size_i     (wr_size_i),
    .mem_rd_en_i   (mem_rd_en_i),
    .addr_mem_rd_i (addr_mem_rd_i),
    .rd_size_i     (rd_size_i),
    .rd_data_o     (rd_data_o),
    .rd_vld_o      (rd_vld_o),
    .hold_req_o    (hold_req_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic misaligned(input logic [63:0] a, input logic [1:0] s);
`ifdef DMEM_MISALIGN_CHK_EN
    int n = 1 << s;
    return (int'(a[2:0]) % n) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference store: size 2^s bytes, rounded down to natural alignment
  function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    int n = 1 << s;
    int b = int'(a[12:0]);
    b = b - (b % n);
    for (int i = 0; i < n; i++) ref_mem[b + i] = d[8*i +: 8];
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] r;
    int b = int'(a[12:0]) & ~7;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[b + i];
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[12:7] = 6'd0;
    return a;
  endfunction

  // One request presented in IDLE, followed through every hold cycle it causes
  task automatic xact(input string tag,
                      input logic we, input logic [63:0] wa, input logic [63:0] wd, input logic [1:0] ws,
                      input logic re, input logic [63:0] ra, input logic [1:0] rs);
    logic wok, rok, exp_err;
    int   h;
    wok     = we && !misaligned(wa, ws);
    rok     = re && !misaligned(ra, rs);
    exp_err = (we && misaligned(wa, ws)) || (re && misaligned(ra, rs));
    h = ((wok && ws != 2'd3) ? 1 : 0) + ((wok && rok) ? 1 : 0);
    if (wok) model_write(wa, wd, ws);
    if (rok) last_rd = model_read(ra);
    mem_wr_en_i = we; addr_mem_wr_i = wa; data_mem_wr_i = wd; wr_size_i = ws;
    mem_rd_en_i = re; addr_mem_rd_i = ra; rd_size_i = rs;
    @(posedge clk); #1;
    mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0;
    addr_mem_wr_i = {$urandom, $urandom}; addr_mem_rd_i = {$urandom, $urandom};
    check({tag, "/hold"}, {63'd0, hold_req_o}, {63'd0, h > 0});
    check({tag, "/err"}, {63'd0, err_o}, {63'd0, exp_err});
    check({tag, "/vld"}, {63'd0, rd_vld_o}, {63'd0, rok && !wok});
    for (int k = 1; k <= h; k++) begin
      @(posedge clk); #1;
      check({tag, "/hold_n"}, {63'd0, hold_req_o}, {63'd0, k < h});
      check({tag, "/vld_n"}, {63'd0, rd_vld_o}, {63'd0, (k == h) && rok && wok});
      check({tag, "/err_n"}, {63'd0, err_o}, 64'd0);
    end
    check({tag, "/data"}, rd_data_o, last_rd);
  endtask

  initial begin
    logic [63:0] wa, ra;
    repeat (2) @(posedge clk);
    #1;
    check("reset/data", rd_data_o, 64'd0);
    check("reset/vld", {63'd0, rd_vld_o}, 64'd0);
    check("reset/hold", {63'd0, hold_req_o}, 64'd0);
    check("reset/err", {63'd0, err_o}, 64'd0);
    rst = 1'b0;

    // Preload the 16-word window used by every scenario
    for (int w = 0; w < 16; w++) begin
      wa = rand_addr();
      wa[6:0] = 7'(w * 8);
      xact("preload", 1'b1, wa, {$urandom, $urandom}, 2'd3, 1'b0, 64'd0, 2'd0);
    end

    xact("dw_wr", 1'b1, 64'h40, 64'h1122334455667788, 2'd3, 1'b0, 64'd0, 2'd0);
    xact("dw_rd", 1'b0, 64'd0, 64'd0, 2'd0, 1'b1, 64'h40, 2'd3);
    check("dw_rd/const", rd_data_o, 64'h1122334455667788);
    xact("byte_wr", 1'b1, 64'h43, 64'hAB, 2'd0, 1'b0, 64'd0, 2'd0);
    xact("byte_rd", 1'b0, 64'd0, 64'd0, 2'd0, 1'b1, 64'h40, 2'd3);
    check("byte_rd/const", rd_data_o, 64'h11223344AB667788);
    xact("cafe_wr", 1'b1, 64'h48, 64'hCAFE, 2'd3, 1'b0, 64'd0, 2'd0);
    xact("half_rd", 1'b1, 64'h46, 64'hBEEF, 2'd1, 1'b1, 64'h48, 2'd3);
    check("half_rd/const", rd_data_o, 64'h000000000000CAFE);
    xact("merge_rd", 1'b0, 64'd0, 64'd0, 2'd0, 1'b1, 64'h40, 2'd3);
    check("merge_rd/const", rd_data_o, 64'hBEEF3344AB667788);
    xact("alias_rd", 1'b0, 64'd0, 64'd0, 2'd0, 1'b1, 64'h2040, 2'd3);
    xact("mis_wr", 1'b1, 64'h42, 64'hDEADBEEF, 2'd2, 1'b0, 64'd0, 2'd0);
    xact("mis_rd", 1'b0, 64'd0, 64'd0, 2'd0, 1'b1, 64'h40, 2'd3);

    // Reset lands in the merge cycle of a byte store; the store must be lost
    mem_wr_en_i = 1'b1; addr_mem_wr_i = 64'h45; data_mem_wr_i = 64'h5A; wr_size_i = 2'd0;
    @(posedge clk); #1;
    mem_wr_en_i = 1'b0;
    check("rst_rmw/hold", {63'd0, hold_req_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rmw/data", rd_data_o, 64'd0);
    check("rst_rmw/vld", {63'd0, rd_vld_o}, 64'd0);
    check("rst_rmw/hold0", {63'd0, hold_req_o}, 64'd0);
    check("rst_rmw/err", {63'd0, err_o}, 64'd0);
    rst = 1'b0;
    last_rd = 64'd0;
    xact("rst_rmw_rd", 1'b0, 64'd0, 64'd0, 2'd0, 1'b1, 64'h40, 2'd3);

    for (int t = 0; t < 300; t++) begin
      wa = rand_addr();
      ra = rand_addr();
      xact("rand", 1'($urandom_range(0, 2) != 0), wa, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
